// File: rtl/picorv32_lite.sv
// Compact multi-cycle RV32I core with the PicoRV32 native memory bus.
// FETCH -> EXEC -> (MEM) -> FETCH; every bus output is registered.
module picorv32_lite #(
   parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   output logic [31:0] pcpi_rs1,
   output logic [31:0] pcpi_rs2,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd,
   input  logic        pcpi_wait,
   input  logic        pcpi_ready,
   input  logic [31:0] irq,
   output logic [31:0] eoi,
   output logic        trap
);
   typedef enum logic [1:0] {FETCH, EXEC, MEM, TRAP} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next, insn, insn_next;
   logic [1:0]  ls_off, ls_off_next;
   logic        mem_valid_next, mem_instr_next, trap_next;
   logic [31:0] mem_addr_next, mem_wdata_next;
   logic [3:0]  mem_wstrb_next;
   logic        rf_we;
   logic [31:0] rf_wdata;
   logic [31:0] regs [1:31];
   logic        unused_inputs;

   assign pcpi_valid = 1'b0;
   assign pcpi_insn  = 32'd0;
   assign pcpi_rs1   = 32'd0;
   assign pcpi_rs2   = 32'd0;
   assign eoi        = 32'd0;
   assign unused_inputs = ^{pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, irq};

   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
   assign opcode = insn[6:0];
   assign rd     = insn[11:7];
   assign f3     = insn[14:12];
   assign rs1    = insn[19:15];
   assign rs2    = insn[24:20];
   assign f7     = insn[31:25];
   assign imm_i  = {{20{insn[31]}}, insn[31:20]};
   assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u  = {insn[31:12], 12'd0};
   assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   // Shared ALU for OP and OP-IMM; insn[30] selects SUB/SRA only where legal.
   logic [31:0] alu_b, alu_out;
   logic        alu_alt;
   logic [4:0]  shamt;
   always_comb begin
      alu_b   = (opcode == 7'b0110011) ? rs2_val : imm_i;
      alu_alt = insn[30] && ((opcode == 7'b0110011) || (f3 == 3'b101));
      shamt   = alu_b[4:0];
      case (f3)
         3'b000:  alu_out = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
         3'b001:  alu_out = rs1_val << shamt;
         3'b010:  alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
         3'b011:  alu_out = {31'd0, rs1_val < alu_b};
         3'b100:  alu_out = rs1_val ^ alu_b;
         3'b101:  alu_out = alu_alt ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'b110:  alu_out = rs1_val | alu_b;
         default: alu_out = rs1_val & alu_b;
      endcase
   end

   logic [31:0] pc_plus4, br_target, jal_target, jalr_target, ls_addr, lane, load_val;
   assign pc_plus4    = pc + 32'd4;
   assign br_target   = pc + imm_b;
   assign jal_target  = pc + imm_j;
   assign jalr_target = (rs1_val + imm_i) & 32'hFFFF_FFFE;
   assign ls_addr     = rs1_val + ((opcode == 7'b0100011) ? imm_s : imm_i);
   assign lane        = mem_rdata >> {ls_off, 3'b000};

   always_comb begin
      case (f3)
         3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_val = {24'd0, lane[7:0]};
         3'b101:  load_val = {16'd0, lane[15:0]};
         default: load_val = lane;
      endcase
   end

   // Next-state, next-output and register writeback for every state.
   logic illegal, taken;
   always_comb begin
      state_next     = state;
      pc_next        = pc;
      insn_next      = insn;
      ls_off_next    = ls_off;
      mem_valid_next = mem_valid;
      mem_instr_next = mem_instr;
      mem_addr_next  = mem_addr;
      mem_wdata_next = mem_wdata;
      mem_wstrb_next = mem_wstrb;
      trap_next      = trap;
      rf_we          = 1'b0;
      rf_wdata       = alu_out;
      illegal        = 1'b0;
      taken          = 1'b0;
      case (state)
         FETCH: begin
            if (!mem_valid) begin
               mem_valid_next = 1'b1;
               mem_instr_next = 1'b1;
               mem_addr_next  = pc;
               mem_wstrb_next = 4'd0;
            end else if (mem_ready) begin
               mem_valid_next = 1'b0;
               insn_next      = mem_rdata;
               state_next     = EXEC;
            end
         end
         EXEC: begin
            pc_next    = pc_plus4;
            state_next = FETCH;
            case (opcode)
               7'b0110111: begin rf_we = 1'b1; rf_wdata = imm_u; end
               7'b0010111: begin rf_we = 1'b1; rf_wdata = pc + imm_u; end
               7'b1101111: begin
                  illegal  = jal_target[1];
                  rf_we    = 1'b1;
                  rf_wdata = pc_plus4;
                  pc_next  = jal_target;
               end
               7'b1100111: begin
                  illegal  = (f3 != 3'b000) || jalr_target[1];
                  rf_we    = 1'b1;
                  rf_wdata = pc_plus4;
                  pc_next  = jalr_target;
               end
               7'b1100011: begin
                  case (f3)
                     3'b000:  taken = rs1_val == rs2_val;
                     3'b001:  taken = rs1_val != rs2_val;
                     3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
                     3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
                     3'b110:  taken = rs1_val < rs2_val;
                     3'b111:  taken = rs1_val >= rs2_val;
                     default: illegal = 1'b1;
                  endcase
                  if (taken) begin
                     pc_next = br_target;
                     illegal = br_target[1];
                  end
               end
               7'b0000011, 7'b0100011: begin
                  if (opcode == 7'b0000011)
                     illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3 == 3'b110);
                  else
                     illegal = f3[2] || (f3 == 3'b011);
                  if ((f3[1:0] == 2'b01 && ls_addr[0]) || (f3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00))
                     illegal = 1'b1;
                  state_next     = MEM;
                  ls_off_next    = ls_addr[1:0];
                  mem_addr_next  = {ls_addr[31:2], 2'b00};
                  mem_instr_next = 1'b0;
                  mem_wstrb_next = 4'd0;
                  if (opcode == 7'b0100011) begin
                     case (f3[1:0])
                        2'b00: begin
                           mem_wdata_next = {4{rs2_val[7:0]}};
                           mem_wstrb_next = 4'b0001 << ls_addr[1:0];
                        end
                        2'b01: begin
                           mem_wdata_next = {2{rs2_val[15:0]}};
                           mem_wstrb_next = 4'b0011 << ls_addr[1:0];
                        end
                        default: begin
                           mem_wdata_next = rs2_val;
                           mem_wstrb_next = 4'b1111;
                        end
                     endcase
                  end
               end
               7'b0010011: begin
                  if (f3 == 3'b001)      illegal = f7 != 7'd0;
                  else if (f3 == 3'b101) illegal = (f7 != 7'd0) && (f7 != 7'h20);
                  rf_we = 1'b1;
               end
               7'b0110011: begin
                  illegal = !((f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
                  rf_we   = 1'b1;
               end
               7'b0001111: illegal = f3 != 3'b000;
               default:    illegal = 1'b1;
            endcase
            if (illegal) begin
               rf_we          = 1'b0;
               pc_next        = pc;
               state_next     = TRAP;
               trap_next      = 1'b1;
               ls_off_next    = ls_off;
               mem_addr_next  = mem_addr;
               mem_instr_next = mem_instr;
               mem_wdata_next = mem_wdata;
               mem_wstrb_next = mem_wstrb;
            end
         end
         MEM: begin
            if (!mem_valid) begin
               mem_valid_next = 1'b1;
            end else if (mem_ready) begin
               mem_valid_next = 1'b0;
               state_next     = FETCH;
               if (opcode == 7'b0000011) begin
                  rf_we    = 1'b1;
                  rf_wdata = load_val;
               end
            end
         end
         default: begin
            trap_next      = 1'b1;
            mem_valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FETCH;
         pc        <= PROGADDR_RESET;
         insn      <= 32'd0;
         ls_off    <= 2'd0;
         mem_valid <= 1'b0;
         mem_instr <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_wstrb <= 4'd0;
         trap      <= 1'b0;
      end else begin
         state     <= state_next;
         pc        <= pc_next;
         insn      <= insn_next;
         ls_off    <= ls_off_next;
         mem_valid <= mem_valid_next;
         mem_instr <= mem_instr_next;
         mem_addr  <= mem_addr_next;
         mem_wdata <= mem_wdata_next;
         mem_wstrb <= mem_wstrb_next;
         trap      <= trap_next;
      end
   end

   // Register file is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (rf_we && rd != 5'd0)
         regs[rd] <= rf_wdata;
   end
endmodule

// File: tb/tb_picorv32_lite.sv
// Directed bench for picorv32_lite: runs small programs against a behavioural
// memory and checks bus traffic, stored results, fetch counts and trap behaviour.
module tb_picorv32_lite;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid, mem_instr, mem_ready = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
   logic [3:0]  mem_wstrb;
   logic        pcpi_valid, trap;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, eoi;

   always #5 clk = ~clk;

   picorv32_lite #(.PROGADDR_RESET(32'h8000_0000)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_wr(1'b0), .pcpi_rd(32'd0), .pcpi_wait(1'b0), .pcpi_ready(1'b0),
      .irq(32'd0), .eoi(eoi), .trap(trap)
   );

   logic [31:0] mem [logic [31:0]];
   int          fetch_cnt [logic [31:0]];
   logic [31:0] log_addr [$];
   logic [31:0] log_wdata [$];
   logic [3:0]  log_wstrb [$];
   logic        log_instr [$];
   int          log_cyc [$];
   int          stall = 0, wait_cnt = 0, cyc = 0;
   int          compared = 0, mismatched = 0;

   function automatic logic [31:0] rd_mem(logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'd0;
   endfunction

   function automatic int fc(logic [31:0] a);
      return fetch_cnt.exists(a) ? fetch_cnt[a] : 0;
   endfunction

   always @(posedge clk) cyc++;

   // One-request-at-a-time memory: ready after `stall` extra cycles, writes honour wstrb.
   always @(negedge clk) begin
      if (reset) begin
         mem_ready = 1'b0;
         wait_cnt  = 0;
      end else if (mem_ready) begin
         mem_ready = 1'b0;
      end else if (mem_valid) begin
         if (wait_cnt < stall) begin
            wait_cnt++;
         end else begin
            logic [31:0] w;
            wait_cnt  = 0;
            mem_ready = 1'b1;
            w         = rd_mem(mem_addr);
            mem_rdata = w;
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            if (mem_wstrb != 4'd0) mem[mem_addr] = w;
            if (mem_instr) fetch_cnt[mem_addr] = fc(mem_addr) + 1;
            log_addr.push_back(mem_addr);
            log_wdata.push_back(mem_wdata);
            log_wstrb.push_back(mem_wstrb);
            log_instr.push_back(mem_instr);
            log_cyc.push_back(cyc);
         end
      end
   end

   function automatic logic [31:0] q_addr(int i);
      return (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic logic [31:0] q_wdata(int i);
      return (i < log_wdata.size()) ? log_wdata[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic logic [3:0] q_wstrb(int i);
      return (i < log_wstrb.size()) ? log_wstrb[i] : 4'hx;
   endfunction
   function automatic logic q_instr(int i);
      return (i < log_instr.size()) ? log_instr[i] : 1'bx;
   endfunction
   function automatic int q_cyc(int i);
      return (i < log_cyc.size()) ? log_cyc[i] : -1000;
   endfunction

   function automatic logic [31:0] enc_u(int imm, int rd, int op);
      logic [31:0] im = imm, d = rd, o = op;
      return {im[19:0], d[4:0], o[6:0]};
   endfunction
   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
      logic [31:0] im = imm, a = rs1, f = f3, d = rd, o = op;
      return {im[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      logic [31:0] im = imm, b = rs2, a = rs1, f = f3;
      return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      logic [31:0] im = imm, b = rs2, a = rs1, f = f3;
      return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      logic [31:0] im = imm, d = rd;
      return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'h6F};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      logic [31:0] s = f7, b = rs2, a = rs1, f = f3, d = rd;
      return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] w);
      mem[a] = w;
   endtask

   task automatic clear_logs();
      log_addr.delete(); log_wdata.delete(); log_wstrb.delete();
      log_instr.delete(); log_cyc.delete(); fetch_cnt.delete();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      clear_logs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_trap(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles && !trap; i++) @(negedge clk);
      check_bit(tag, trap, 1'b1);
   endtask

   task automatic check_quiet(input string tag, input int cycles);
      int n;
      n = log_addr.size();
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_bit({tag, "_valid"}, mem_valid, 1'b0);
      end
      check_output({tag, "_reqs"}, log_addr.size(), n);
   endtask

   initial begin
      localparam logic [31:0] B = 32'h8000_0000;
      localparam logic [31:0] D = 32'h3000_0000;

      // Reset state while reset is held.
      #12;
      check_bit("rst_valid", mem_valid, 1'b0);
      check_bit("rst_instr", mem_instr, 1'b0);
      check_output("rst_addr", mem_addr, 32'd0);
      check_output("rst_wdata", mem_wdata, 32'd0);
      check_output("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check_bit("rst_trap", trap, 1'b0);
      check_bit("rst_pcpi", pcpi_valid, 1'b0);
      check_output("rst_eoi", eoi, 32'd0);

      // Main program: stores, byte/half loads, loop, JAL, shifts/compares, ECALL.
      mem.delete();
      put(32'h0000_2000, 32'h80FF_0000);
      put(B + 32'h00, enc_u(32'h30000, 1, 7'h37));
      put(B + 32'h04, enc_i(42, 0, 0, 2, 7'h13));
      put(B + 32'h08, enc_s(8, 2, 1, 2));
      put(B + 32'h0C, enc_u(32'h12345, 3, 7'h37));
      put(B + 32'h10, enc_i(32'h6AB, 3, 0, 3, 7'h13));
      put(B + 32'h14, enc_u(32'h2, 4, 7'h37));
      put(B + 32'h18, enc_s(1, 3, 4, 0));
      put(B + 32'h1C, enc_i(3, 4, 0, 5, 7'h03));
      put(B + 32'h20, enc_i(3, 4, 4, 6, 7'h03));
      put(B + 32'h24, enc_i(2, 4, 1, 7, 7'h03));
      put(B + 32'h28, enc_s(16, 5, 1, 2));
      put(B + 32'h2C, enc_s(20, 6, 1, 2));
      put(B + 32'h30, enc_s(24, 7, 1, 2));
      put(B + 32'h34, enc_i(3, 0, 0, 8, 7'h13));
      put(B + 32'h38, enc_i(-1, 8, 0, 8, 7'h13));
      put(B + 32'h3C, enc_b(-4, 0, 8, 1));
      put(B + 32'h40, enc_j(16, 10));
      put(B + 32'h50, enc_s(28, 10, 1, 2));
      put(B + 32'h54, enc_i(-8, 0, 0, 11, 7'h13));
      put(B + 32'h58, enc_i(32'h401, 11, 5, 12, 7'h13));
      put(B + 32'h5C, enc_i(28, 11, 5, 13, 7'h13));
      put(B + 32'h60, enc_r(0, 2, 11, 2, 14));
      put(B + 32'h64, enc_r(0, 2, 11, 3, 15));
      put(B + 32'h68, enc_r(32'h20, 11, 2, 0, 16));
      put(B + 32'h6C, enc_s(32, 12, 1, 2));
      put(B + 32'h70, enc_s(36, 13, 1, 2));
      put(B + 32'h74, enc_s(40, 14, 1, 2));
      put(B + 32'h78, enc_s(44, 15, 1, 2));
      put(B + 32'h7C, enc_s(48, 16, 1, 2));
      put(B + 32'h80, 32'h0000_0073);
      stall = 0;
      apply_reset();
      wait_trap("prog_trap", 2000);

      check_output("fetch0_addr", q_addr(0), B);
      check_bit("fetch0_instr", q_instr(0), 1'b1);
      check_output("fetch0_wstrb", {28'd0, q_wstrb(0)}, 32'd0);
      check_output("fetch1_addr", q_addr(1), B + 32'd4);
      check_output("alu_latency", q_cyc(1) - q_cyc(0), 3);
      check_output("mem_latency", q_cyc(4) - q_cyc(2), 5);
      check_output("sw_addr", q_addr(3), 32'h3000_0008);
      check_output("sw_wstrb", {28'd0, q_wstrb(3)}, 32'hF);
      check_output("sw_wdata", q_wdata(3), 32'h0000_002A);
      check_bit("sw_instr", q_instr(3), 1'b0);
      check_output("sb_addr", q_addr(8), 32'h0000_2000);
      check_output("sb_wstrb", {28'd0, q_wstrb(8)}, 32'h2);
      check_output("sb_wdata", q_wdata(8), 32'hABAB_ABAB);
      check_output("lb_result", rd_mem(D + 32'h10), 32'hFFFF_FF80);
      check_output("lbu_result", rd_mem(D + 32'h14), 32'h0000_0080);
      check_output("lh_result", rd_mem(D + 32'h18), 32'hFFFF_80FF);
      check_output("loop_body_fetches", fc(B + 32'h38), 3);
      check_output("loop_exit_fetches", fc(B + 32'h40), 1);
      check_output("jal_link", rd_mem(D + 32'h1C), B + 32'h44);
      check_output("jal_skip", fc(B + 32'h44), 0);
      check_output("jal_target", fc(B + 32'h50), 1);
      check_output("srai_result", rd_mem(D + 32'h20), 32'hFFFF_FFFC);
      check_output("srli_result", rd_mem(D + 32'h24), 32'h0000_000F);
      check_output("slt_result", rd_mem(D + 32'h28), 32'd1);
      check_output("sltu_result", rd_mem(D + 32'h2C), 32'd0);
      check_output("sub_result", rd_mem(D + 32'h30), 32'd50);
      check_output("ecall_fetch", fc(B + 32'h80), 1);
      check_quiet("ecall_halt", 20);

      // All-zero opcode traps straight after its fetch.
      mem.delete();
      apply_reset();
      wait_trap("zero_op_trap", 200);
      check_output("zero_op_reqs", log_addr.size(), 1);
      check_quiet("zero_op_halt", 10);

      // Misaligned LW traps in EXEC without a bus request.
      mem.delete();
      put(B + 32'h00, enc_u(32'h2, 4, 7'h37));
      put(B + 32'h04, enc_i(2, 4, 2, 5, 7'h03));
      apply_reset();
      wait_trap("lw_mis_trap", 200);
      check_output("lw_mis_reqs", log_addr.size(), 2);
      check_bit("lw_mis_last_is_fetch", q_instr(1), 1'b1);

      // Reset in the middle of a stalled fetch abandons it and restarts at the reset vector.
      put(B + 32'h04, enc_i(1, 0, 0, 5, 7'h13));
      stall = 6;
      apply_reset();
      for (int i = 0; i < 20 && !mem_valid; i++) @(negedge clk);
      check_bit("stall_valid", mem_valid, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_bit("midrst_valid", mem_valid, 1'b0);
      check_bit("midrst_instr", mem_instr, 1'b0);
      check_output("midrst_addr", mem_addr, 32'd0);
      check_output("midrst_reqs", log_addr.size(), 0);
      stall = 2;
      apply_reset();
      repeat (12) @(negedge clk);
      check_output("restart_addr", q_addr(0), B);
      check_output("restart_next", q_addr(1), B + 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
